muldiv_seq: RTL and testbench

- Iterative multiply/divide unit in the EXE stage, directly downstream of the RF stage.
- Consumes the RF read operands (qa → s, qb → t) and a decoded muldiv opcode.
- Implements MULT/MULTU/DIV/DIVU into the HI/LO registers, plus MFHI/MFLO/MTHI/MTLO.
- Requests a pipeline stall when an instruction needs HI/LO, or the unit, while an operation is still in flight.

---
 rtl/muldiv_seq_pkg.sv | 36 +++
 rtl/muldiv_seq_if.sv | 30 +++
 rtl/muldiv_seq_step.sv | 37 +++
 rtl/muldiv_seq.sv | 147 ++++++++++++++
 tb/tb_muldiv_seq.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg
//   Shared definitions for the iterative multiply/divide unit:
//   muldiv opcodes (4-bit ctl encoding), FSM state encodings and
//   small opcode classification helpers.
//   No ports.
package muldiv_seq_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_RUN  = 2'd1,
        MDS_FIX  = 2'd2
    } mds_e;

    // Opcodes that launch a multi-cycle iteration.
    function automatic logic is_arith(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Any listed opcode other than NOP; unlisted codes behave as NOP.
    function automatic logic is_known(input logic [3:0] op);
        return (op != MD_NOP) && (op <= MD_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if
//   Pipeline-side bundle of the multiply/divide unit.
//   hold    : stall from every other source (never includes stall_o)
//   ctl     : muldiv opcode
//   s, t    : rs / rt operands
//   res     : HI or LO for MFHI/MFLO, else 0
//   busy    : unit is not idle
//   stall_o : unit requests a pipeline stall
//   master = pipeline side, slave = muldiv unit.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             hold;
    logic [3:0]       ctl;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] res;
    logic             busy;
    logic             stall_o;

    modport master (
        output hold, ctl, s, t,
        input  res, busy, stall_o
    );

    modport slave (
        input  hold, ctl, s, t,
        output res, busy, stall_o
    );
endinterface

// File: rtl/muldiv_seq_step.sv
// muldiv_seq_step
//   Combinational single radix-2 iteration on unsigned magnitudes.
//   is_div  : 0 = shift-add multiply, 1 = restoring shift-subtract divide
//   acc     : multiply {partial product, multiplier bits}
//             divide   {partial remainder, dividend/quotient bits}
//   opnd    : multiplicand (multiply) or divisor (divide)
//   acc_nxt : accumulator after one iteration
module muldiv_seq_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_nxt
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    always_comb begin
        // Multiply: the carry out of the add becomes the new top bit as the
        // whole accumulator shifts right.
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // Divide: remainder shifted left with the next dividend bit appended;
        // the extra top bit keeps the compare exact.
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh[WIDTH-1:0] - opnd;
        acc_nxt = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (rem_sh >= {1'b0, opnd}) begin
                acc_nxt = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq
//   Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and
//   MFHI/MFLO/MTHI/MTLO access, sitting in the EXE stage.
//   clk : pipeline clock
//   rst : synchronous active-high reset
//   bus : muldiv_seq_if.slave (hold, ctl, s, t in; res, busy, stall_o out)
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   MDS_IDLE | accepts ops when hold=0; HI/LO readable/writable
//   MDS_RUN  | one radix-2 iteration per cycle, WIDTH cycles
//   MDS_FIX  | sign fixup, write HI/LO, return to idle
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    muldiv_seq_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mds_e               state;
    mds_e               state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;

    logic               accept;
    logic               start;
    logic               div_op;
    logic               sgn_op;
    logic               s_neg;
    logic               t_neg;
    logic [WIDTH-1:0]   s_mag;
    logic [WIDTH-1:0]   t_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    muldiv_seq_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc     (acc),
        .opnd    (opnd),
        .acc_nxt (acc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MDS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        accept    = (state == MDS_IDLE) && !bus.hold;
        start     = accept && is_arith(bus.ctl);
        state_nxt = state;
        case (state)
            MDS_IDLE: if (start) state_nxt = MDS_RUN;
            MDS_RUN:  if (cnt == CNT_LAST) state_nxt = MDS_FIX;
            MDS_FIX:  state_nxt = MDS_IDLE;
            default:  state_nxt = MDS_IDLE;
        endcase
    end

    // stall_o deliberately ignores hold so the pipeline stall logic has no loop.
    always_comb begin
        bus.busy    = (state != MDS_IDLE);
        bus.stall_o = bus.busy && is_known(bus.ctl);
        bus.res     = '0;
        if (bus.ctl == MD_MFHI) begin
            bus.res = hi;
        end else if (bus.ctl == MD_MFLO) begin
            bus.res = lo;
        end
    end

    always_comb begin
        div_op = (bus.ctl == MD_DIV) || (bus.ctl == MD_DIVU);
        sgn_op = (bus.ctl == MD_MULT) || (bus.ctl == MD_DIV);
        s_neg  = sgn_op && bus.s[WIDTH-1];
        t_neg  = sgn_op && bus.t[WIDTH-1];
        // Magnitudes wrap mod 2^WIDTH, so the most negative value maps to itself.
        s_mag  = s_neg ? -bus.s : bus.s;
        t_mag  = t_neg ? -bus.t : bus.t;

        prod_fix = neg_res ? -acc : acc;
        // A zero divisor leaves an all-ones quotient untouched; the remainder
        // then holds |s|, and restoring the dividend sign yields s as presented.
        quo_fix  = (neg_res && (opnd != '0)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                MDS_IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        is_div  <= div_op;
                        neg_res <= s_neg ^ t_neg;
                        neg_rem <= s_neg;
                        opnd    <= div_op ? t_mag : s_mag;
                        acc     <= {{WIDTH{1'b0}}, (div_op ? s_mag : t_mag)};
                    end else if (accept && (bus.ctl == MD_MTHI)) begin
                        hi <= bus.s;
                    end else if (accept && (bus.ctl == MD_MTLO)) begin
                        lo <= bus.s;
                    end
                end
                MDS_RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CNT_W'(1);
                end
                MDS_FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq
//   Self-checking bench for muldiv_seq: directed corner cases, stall and
//   timing scenarios, reset/hold behaviour and randomized operations
//   compared against a plain-arithmetic HI/LO model.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    muldiv_seq_if #(.WIDTH(W)) bus ();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] m_hi    = '0;
    logic [W-1:0] m_lo    = '0;
    logic         rand_hold = 1'b0;

    // Architectural reference: 64-bit integer arithmetic on the operands.
    task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MD_MULTU: begin
                p = {32'h0, a} * {32'h0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            MD_MULT: begin
                p = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            MD_DIVU: begin
                if (b == '0) begin
                    m_hi = a;
                    m_lo = '1;
                end else begin
                    m_hi = a % b;
                    m_lo = a / b;
                end
            end
            MD_DIV: begin
                if (b == '0) begin
                    m_hi = a;
                    m_lo = '1;
                end else begin
                    p = sa % sb;
                    m_hi = p[31:0];
                    p = sa / sb;
                    m_lo = p[31:0];
                end
            end
            MD_MTHI: m_hi = a;
            MD_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Present an op at a negedge, wait out any stall, let it be accepted.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.hold = 1'b0;
        bus.ctl  = op;
        bus.s    = a;
        bus.t    = b;
        #1;
        while (bus.stall_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout stall_o=%b required 0", bus.stall_o);
        end
        @(posedge clk);
        #1;
        model_op(op, a, b);
        bus.ctl = MD_NOP;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (bus.busy && guard < 100) begin
            @(negedge clk);
            bus.hold = rand_hold ? 1'($urandom_range(0, 1)) : 1'b0;
            guard++;
        end
        bus.hold = 1'b0;
        if (guard >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout busy=%b required 0", bus.busy);
        end
    endtask

    task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.hold = 1'b0;
        bus.ctl  = MD_MFHI;
        #1;
        while (bus.stall_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL read_timeout stall_o=%b required 0", bus.stall_o);
        end
        #1;
        hi = bus.res;
        bus.ctl = MD_MFLO;
        #1;
        lo = bus.res;
        bus.ctl = MD_NOP;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        bus.hold = 1'b0;
        bus.ctl  = MD_MULT;
        bus.s    = 32'd5;
        bus.t    = 32'd6;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b required 0", bus.busy);
        end
        n_tests++;
        if (bus.stall_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall got %b required 0", bus.stall_o);
        end
        bus.ctl = MD_MFHI;
        #1;
        n_tests++;
        if (bus.res !== 32'h0) begin
            n_fail++; $display("FAIL reset_hi got %h required 0", bus.res);
        end
        bus.ctl = MD_MFLO;
        #1;
        n_tests++;
        if (bus.res !== 32'h0) begin
            n_fail++; $display("FAIL reset_lo got %h required 0", bus.res);
        end
        bus.ctl = MD_NOP;
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_hold_idle();
        @(negedge clk);
        bus.hold = 1'b1;
        bus.ctl  = MD_MULT;
        bus.s    = 32'd3;
        bus.t    = 32'd4;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL hold_idle_busy got %b required 0", bus.busy);
        end
        bus.ctl  = MD_NOP;
        bus.hold = 1'b0;
    endtask

    task automatic test_multu_timing();
        int busy_cycles;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        busy_cycles = 0;
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
            else break;
        end
        n_tests++;
        if (busy_cycles != 33) begin
            n_fail++; $display("FAIL multu_busy_cycles got %0d required 33", busy_cycles);
        end
        read_hilo(hi, lo);
        n_tests++;
        if (hi !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL multu_hi got %h required fffffffe", hi);
        end
        n_tests++;
        if (lo !== 32'h0000_0001) begin
            n_fail++; $display("FAIL multu_lo got %h required 00000001", lo);
        end
    endtask

    task automatic test_directed();
        logic [3:0]   d_op [9] = '{MD_MULT, MD_DIV, MD_DIV, MD_DIVU, MD_DIV,
                                   MD_MULT, MD_DIVU, MD_MULT, MD_DIV};
        logic [W-1:0] d_s  [9] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_1234,
                                   32'hFFFF_FFFB, 32'h8000_0000, 32'h0000_0007, 32'h8000_0000,
                                   32'd100};
        logic [W-1:0] d_t  [9] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'h0, 32'h0,
                                   32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF9};
        logic [W-1:0] d_hi [9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0000_1234,
                                   32'hFFFF_FFFB, 32'h4000_0000, 32'd7, 32'hFFFF_FFFF,
                                   32'd2};
        logic [W-1:0] d_lo [9] = '{32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFF, 32'h0, 32'h0, 32'h8000_0000,
                                   32'hFFFF_FFF2};
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        for (int i = 0; i < 9; i++) begin
            issue(d_op[i], d_s[i], d_t[i]);
            wait_idle();
            read_hilo(hi, lo);
            n_tests++;
            if (hi !== d_hi[i]) begin
                n_fail++; $display("FAIL directed_hi[%0d] got %h required %h", i, hi, d_hi[i]);
            end
            n_tests++;
            if (lo !== d_lo[i]) begin
                n_fail++; $display("FAIL directed_lo[%0d] got %h required %h", i, lo, d_lo[i]);
            end
        end
    endtask

    task automatic test_dependent();
        int stalled;
        stalled = 0;
        issue(MD_MULT, 32'd6, 32'd7);
        @(negedge clk);
        @(negedge clk);
        bus.ctl = MD_MFLO;
        #1;
        while (bus.stall_o && stalled < 100) begin
            stalled++;
            @(negedge clk);
        end
        n_tests++;
        if (stalled != 32) begin
            n_fail++; $display("FAIL dep_stall_cycles got %0d required 32", stalled);
        end
        n_tests++;
        if (bus.res !== 32'd42) begin
            n_fail++; $display("FAIL dep_mflo got %h required 0000002a", bus.res);
        end
        bus.ctl = MD_MFHI;
        #1;
        n_tests++;
        if (bus.res !== 32'h0) begin
            n_fail++; $display("FAIL dep_mfhi got %h required 0", bus.res);
        end
        bus.ctl = MD_NOP;
    endtask

    task automatic test_back_to_back();
        int stalled;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        stalled = 0;
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd9);
        @(negedge clk);
        @(negedge clk);
        bus.ctl = MD_MULT;
        bus.s   = 32'h0001_2345;
        bus.t   = 32'hFFFF_FFF0;
        #1;
        while (bus.stall_o && stalled < 100) begin
            stalled++;
            @(negedge clk);
        end
        n_tests++;
        if (stalled != 32) begin
            n_fail++; $display("FAIL b2b_stall_cycles got %0d required 32", stalled);
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle_before_accept busy=%b required 0", bus.busy);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_accept busy=%b required 1", bus.busy);
        end
        model_op(MD_MULT, 32'h0001_2345, 32'hFFFF_FFF0);
        bus.ctl = MD_NOP;
        wait_idle();
        read_hilo(hi, lo);
        n_tests++;
        if (hi !== m_hi) begin
            n_fail++; $display("FAIL b2b_hi got %h required %h", hi, m_hi);
        end
        n_tests++;
        if (lo !== m_lo) begin
            n_fail++; $display("FAIL b2b_lo got %h required %h", lo, m_lo);
        end
    endtask

    // An MTLO held while busy must land after the product, not before it.
    task automatic test_mt_while_busy();
        int stalled;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        stalled = 0;
        issue(MD_MULTU, 32'hDEAD_BEEF, 32'h0001_0000);
        @(negedge clk);
        @(negedge clk);
        bus.ctl = MD_MTLO;
        bus.s   = 32'hCAFE_F00D;
        #1;
        while (bus.stall_o && stalled < 100) begin
            stalled++;
            @(negedge clk);
        end
        n_tests++;
        if (stalled != 32) begin
            n_fail++; $display("FAIL mt_busy_stall_cycles got %0d required 32", stalled);
        end
        @(posedge clk);
        #1;
        model_op(MD_MTLO, 32'hCAFE_F00D, 32'h0);
        bus.ctl = MD_NOP;
        read_hilo(hi, lo);
        n_tests++;
        if (hi !== 32'h0000_DEAD) begin
            n_fail++; $display("FAIL mt_busy_hi got %h required 0000dead", hi);
        end
        n_tests++;
        if (lo !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL mt_busy_lo got %h required cafef00d", lo);
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        issue(MD_MTHI, 32'h1111_1111, 32'h0);
        issue(MD_MTLO, 32'h2222_2222, 32'h0);
        issue(MD_DIVU, 32'hFFFF_1234, 32'd3);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL midop_reset_busy got %b required 0", bus.busy);
        end
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        read_hilo(hi, lo);
        n_tests++;
        if (hi !== 32'h0) begin
            n_fail++; $display("FAIL midop_reset_hi got %h required 0", hi);
        end
        n_tests++;
        if (lo !== 32'h0) begin
            n_fail++; $display("FAIL midop_reset_lo got %h required 0", lo);
        end

        @(negedge clk);
        bus.hold = 1'b1;
        bus.ctl  = MD_MTHI;
        bus.s    = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.hold = 1'b0;
        bus.ctl  = MD_NOP;
        read_hilo(hi, lo);
        n_tests++;
        if (hi !== 32'h0) begin
            n_fail++; $display("FAIL mthi_hold_hi got %h required 0", hi);
        end
        issue(MD_MTHI, 32'hA5A5_A5A5, 32'h0);
        read_hilo(hi, lo);
        n_tests++;
        if (hi !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL mthi_hi got %h required a5a5a5a5", hi);
        end
    endtask

    task automatic test_random();
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 5))
                0:       op = MD_MULT;
                1:       op = MD_MULTU;
                2:       op = MD_DIV;
                3:       op = MD_DIVU;
                4:       op = MD_MTHI;
                default: op = MD_MTLO;
            endcase
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       a = 32'h8000_0000;
                2:       b = '1;
                3:       b = b >> $urandom_range(1, 31);
                default: ;
            endcase
            rand_hold = 1'b1;
            issue(op, a, b);
            wait_idle();
            rand_hold = 1'b0;
            read_hilo(hi, lo);
            n_tests++;
            if (hi !== m_hi) begin
                n_fail++;
                $display("FAIL rand_hi[%0d] op=%0d s=%h t=%h got %h required %h", i, op, a, b, hi, m_hi);
            end
            n_tests++;
            if (lo !== m_lo) begin
                n_fail++;
                $display("FAIL rand_lo[%0d] op=%0d s=%h t=%h got %h required %h", i, op, a, b, lo, m_lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_idle();
        test_multu_timing();
        test_directed();
        test_dependent();
        test_back_to_back();
        test_mt_while_busy();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
